nios2vga_pio_out: RTL
=====================

NIOS2VGA_PIO_OUT -- requirements
Module: nios2vga_pio_out

Interface
REQ-001 SHALL have parameter WIDTH, default 8: out_port width, legal 1..32.
REQ-002 SHALL have parameter RESET_VALUE, default 0: DATA register value after reset, WIDTH bits.
REQ-003 SHALL have parameter PULSE_CYCLES, default 16: pulse duration in clk cycles, legal 1..65535.
REQ-004 SHALL have port clk, input, 1: single clock, all state on rising edge.
REQ-005 SHALL have port reset_n, input, 1: asynchronous, active-low reset.
REQ-006 SHALL have port address, input, 3: Avalon-MM slave word address.
REQ-007 SHALL have port chipselect, input, 1: slave select.
REQ-008 SHALL have port write_n, input, 1: active-low write strobe.
REQ-009 SHALL have port writedata, input, 32: write data.
REQ-010 SHALL have port readdata, output, 32: combinational read data, zero wait states.
REQ-011 SHALL have port out_port, output, WIDTH: driven output pins.
REQ-012 SHALL have port pulse_busy, output, 1: high while a pulse is active.

Function
REQ-013 SHALL perform a write when chipselect=1 and write_n=0 at a rising clk edge; the new value is visible on out_port the following cycle.
REQ-014 SHALL map address 0 to DATA: write loads writedata[WIDTH-1:0]; read returns DATA zero-extended.
REQ-015 SHALL map address 4 to OUTSET: write sets DATA |= writedata[WIDTH-1:0]; read returns 0.
REQ-016 SHALL map address 5 to OUTCLEAR: write clears DATA &= ~writedata[WIDTH-1:0]; read returns 0.
REQ-017 SHALL map address 1 to PULSE: write with nonzero mask starts a pulse; read returns {pulse_busy, 15'b0, remaining count[15:0]}, where count is truncated to width.
REQ-018 SHALL return 0 on reads of addresses 2, 3, 6 and 7, and SHALL ignore writes to them.
REQ-019 SHALL drive out_port = DATA ^ PMASK while ACTIVE, and out_port = DATA while IDLE.
REQ-020 SHALL implement pulse FSM IDLE -> ACTIVE on a PULSE write with nonzero mask: PMASK is loaded with the mask and CNT with PULSE_CYCLES.
REQ-021 SHALL decrement CNT once per cycle in ACTIVE; when CNT=1, SHALL go to IDLE at the next edge, clearing PMASK and CNT, so that the inversion lasts exactly PULSE_CYCLES cycles.
REQ-022 SHALL retrigger on a PULSE write while ACTIVE: PMASK |= mask and CNT is reloaded to PULSE_CYCLES.
REQ-023 SHALL ignore a PULSE write with a zero mask in both states.
REQ-024 SHALL apply DATA writes during ACTIVE normally, with the pulse inversion applied on top of the new DATA.
REQ-025 SHALL assert pulse_busy exactly when the state is ACTIVE.
REQ-026 SHALL ignore writedata bits above WIDTH-1 in all registers.

Reset
REQ-027 SHALL, on reset_n low, asynchronously set DATA=RESET_VALUE, PMASK=0, CNT=0 and state=IDLE, giving out_port=RESET_VALUE and pulse_busy=0.
REQ-028 SHALL abort any pulse in progress on reset, with no residual inversion after reset_n is released.
REQ-029 SHALL accept a write on the first rising edge after reset_n deasserts.

Configuration
REQ-030 SHALL compile in the pulse logic (address 1, PMASK, CNT, FSM) when macro NIOS2VGA_PIO_PULSE_EN is defined.
REQ-031 SHALL, without NIOS2VGA_PIO_PULSE_EN: read address 1 as 0, ignore writes to it, tie pulse_busy to 0, and drive out_port=DATA; the PULSE_CYCLES parameter remains declared but has no effect.

Structure
REQ-032 SHALL place the register address constants (ADDR_DATA=0, ADDR_PULSE=1, ADDR_OUTSET=4, ADDR_OUTCLEAR=5) and the pulse state enum {IDLE, ACTIVE} in package nios2vga_pio_pkg.
REQ-033 SHALL implement the pulse FSM and counter as sub-module nios2vga_pio_pulse_timer, with inputs start/mask and outputs pmask/busy/count.

Verification
REQ-034 SHALL cover reset: WIDTH=8, RESET_VALUE=8'hA5 -> out_port=8'hA5, pulse_busy=0 and readdata(0)=32'h000000A5.
REQ-035 SHALL cover set/clear: write DATA=8'h0F, OUTSET=8'hF0, OUTCLEAR=8'h03 -> out_port successively 8'h0F, 8'hFF, 8'hFC, each one cycle after its write.
REQ-036 SHALL cover a pulse: DATA=8'h00, PULSE_CYCLES=4, write PULSE=8'h81 -> out_port=8'h81 for exactly 4 cycles, then 8'h00, with pulse_busy matching.
REQ-037 SHALL cover retrigger: PULSE=8'h01 followed 2 cycles later by PULSE=8'h02 (PULSE_CYCLES=4) -> out_port=8'h01 for 2 cycles, then 8'h03 for 4 cycles, then 8'h00.
REQ-038 SHALL cover reset mid-pulse: assert reset_n low during ACTIVE -> out_port=RESET_VALUE immediately, pulse_busy=0, and no inversion after release.
REQ-039 SHALL cover macro undefined: write PULSE=8'hFF -> out_port unchanged, readdata(1)=0 and pulse_busy=0.

Source files
------------

// File: rtl/nios2vga_pio_pkg.sv
// Shared constants and types for the nios2vga PIO output port.
// Register map and pulse FSM state encoding.
package nios2vga_pio_pkg;

  localparam logic [2:0] ADDR_DATA     = 3'd0;
  localparam logic [2:0] ADDR_PULSE    = 3'd1;
  localparam logic [2:0] ADDR_OUTSET   = 3'd4;
  localparam logic [2:0] ADDR_OUTCLEAR = 3'd5;

  localparam int CNT_W = 16;

  typedef enum logic {
    IDLE,
    ACTIVE
  } pulse_state_t;

endpackage

// File: rtl/nios2vga_pio_pulse_timer.sv
// Pulse FSM: inverts a bit mask for PULSE_CYCLES clocks.
// A start with nonzero mask while active ORs the mask and reloads.
module nios2vga_pio_pulse_timer
  import nios2vga_pio_pkg::*;
#(
  parameter int WIDTH        = 8,
  parameter int PULSE_CYCLES = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [WIDTH-1:0] mask,
  output logic [WIDTH-1:0] pmask,
  output logic             busy,
  output logic [CNT_W-1:0] count
);

  localparam logic [CNT_W-1:0] LOAD = CNT_W'(PULSE_CYCLES);

  pulse_state_t state;
  logic         go;

  assign go = start && (|mask);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      pmask <= '0;
      count <= '0;
      busy  <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (go) begin
            state <= ACTIVE;
            pmask <= mask;
            count <= LOAD;
            busy  <= 1'b1;
          end
        end
        ACTIVE: begin
          // Retrigger wins over expiry on the same edge.
          if (go) begin
            pmask <= pmask | mask;
            count <= LOAD;
          end else if (count == CNT_W'(1)) begin
            state <= IDLE;
            pmask <= '0;
            count <= '0;
            busy  <= 1'b0;
          end else begin
            count <= count - CNT_W'(1);
          end
        end
        default: begin
          state <= IDLE;
          pmask <= '0;
          count <= '0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/nios2vga_pio_out.sv
// Avalon-MM output PIO with set/clear and optional timed pulse.
// Pulse logic is built only when NIOS2VGA_PIO_PULSE_EN is defined.
module nios2vga_pio_out
  import nios2vga_pio_pkg::*;
#(
  parameter int               WIDTH        = 8,
  parameter logic [WIDTH-1:0] RESET_VALUE  = '0,
  parameter int               PULSE_CYCLES = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  output logic [WIDTH-1:0] out_port,
  output logic             pulse_busy
);

  logic             wr;
  logic [WIDTH-1:0] wd;
  logic [WIDTH-1:0] data;
  logic             sel_data;
  logic             sel_set;
  logic             sel_clr;
  logic             unused_wd;

  assign wr        = chipselect && !write_n;
  assign wd        = writedata[WIDTH-1:0];
  assign unused_wd = ^writedata;
  assign sel_data  = wr && (address == ADDR_DATA);
  assign sel_set   = wr && (address == ADDR_OUTSET);
  assign sel_clr   = wr && (address == ADDR_OUTCLEAR);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data <= RESET_VALUE;
    end else begin
      unique case (1'b1)
        sel_data: data <= wd;
        sel_set:  data <= data | wd;
        sel_clr:  data <= data & ~wd;
        default:  data <= data;
      endcase
    end
  end

`ifdef NIOS2VGA_PIO_PULSE_EN
  logic [WIDTH-1:0] pmask;
  logic             busy;
  logic [CNT_W-1:0] count;

  nios2vga_pio_pulse_timer #(
    .WIDTH       (WIDTH),
    .PULSE_CYCLES(PULSE_CYCLES)
  ) u_timer (
    .clk    (clk),
    .reset_n(reset_n),
    .start  (wr && (address == ADDR_PULSE)),
    .mask   (wd),
    .pmask  (pmask),
    .busy   (busy),
    .count  (count)
  );

  assign pulse_busy = busy;
  assign out_port   = data ^ pmask;
`else
  logic [CNT_W-1:0] unused_pc;

  assign unused_pc  = CNT_W'(PULSE_CYCLES);
  assign pulse_busy = 1'b0;
  assign out_port   = data;
`endif

  always_comb begin
    readdata = '0;
    unique case (address)
      ADDR_DATA:  readdata = 32'(data);
`ifdef NIOS2VGA_PIO_PULSE_EN
      ADDR_PULSE: readdata = {busy, 15'b0, count};
`endif
      default:    readdata = '0;
    endcase
  end

endmodule
